pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register; generalises the fixed-field inter-stage latches (IF/ID ... MEM/WB) of the 16-bit core.
- Carries an arbitrary-width datapath bundle plus a control bundle between stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream stalls need no combinational path from downstream ready.
- Supports synchronous flush, which inserts a bubble with control bits forced to a safe value.

Parameters:
DATA_W, 48, width of datapath bundle (e.g. result, read data, next PC).
CTRL_W, 8, width of control bundle (reg_write, mem_to_reg, halt, write select, ...).
CTRL_RST, 0, value driven on out_ctrl when empty, after reset, and after flush.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream has a bundle.
in_ready  out  1  stage can accept; registered, depends only on state.
in_data  in  DATA_W  upstream datapath bundle.
in_ctrl  in  CTRL_W  upstream control bundle.
flush  in  1  synchronous kill of all held entries.
out_valid  out  1  main entry holds a bundle.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  main entry datapath.
out_ctrl  out  CTRL_W  main entry control; CTRL_RST when out_valid=0.
count  out  2  occupancy, 0..2.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Storage: main entry (drives outputs) and skid entry. State is EMPTY, ONE or FULL; count is 0/1/2.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL).
- out_valid = (state != EMPTY).
- in_ready is a function of state only; no out_ready -> in_ready combinational path.
- Data is captured only on in_fire. in_data and in_ctrl are ignored when in_valid=0 or in_ready=0.
- Latency: a bundle accepted at edge N is visible on out_* after edge N. Throughput is 1 per cycle while out_ready=1.
- EMPTY:
  - in_fire: main<=in, go to ONE.
  - else: stay.
- ONE:
  - in_fire & out_fire: main<=in, stay ONE.
  - in_fire only: skid<=in, go to FULL.
  - out_fire only: go to EMPTY.
  - neither: hold.
- FULL (in_ready=0):
  - out_fire: main<=skid, go to ONE.
  - else: hold both entries.
- Ordering is strictly FIFO; bundles are never duplicated or dropped except by flush.
- out_data holds its last value when EMPTY. out_ctrl is forced to CTRL_RST whenever out_valid=0.
- flush has priority over all other events in the same cycle:
  - Next state is EMPTY.
  - Any in_fire or out_fire in the flush cycle is discarded and not stored.
  - Downstream may still sample the pre-flush out_* in the flush cycle; out_fire that cycle counts as consumed.
- Reset: async assert forces state=EMPTY, count=0, out_valid=0, in_ready=1, out_data=0, out_ctrl=CTRL_RST, skid=0. Deassertion is synchronous to clk; the first accept can happen on the first edge after deassertion.
- Reset mid-operation: all held bundles are lost and no partial outputs are produced.
- Stall: with out_ready=0, at most two bundles are absorbed, then in_ready drops. Outputs remain stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset: assert rst mid-cycle with count=2 -> immediately out_valid=0, out_ctrl=CTRL_RST, out_data=0, count=0, in_ready=1.
- Streaming: out_ready=1, feed in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each; count stays 1; in_ready stays 1.
- Backpressure: out_ready=0, feed A,B,C -> A,B accepted, count=2, in_ready=0, C held upstream. Raise out_ready -> outputs A,B,C in order, with no gap after B.
- Flush with simultaneous input: count=2, assert flush together with in_valid=1 (in_data=0x55) -> next cycle count=0, out_valid=0, out_ctrl=CTRL_RST, 0x55 never appears.
- Bubble control: CTRL_RST=8'hA5, state EMPTY -> out_ctrl=8'hA5. Accept ctrl=8'h01 -> out_ctrl=8'h01. Drain -> out_ctrl=8'hA5 again.
- Random: random in_valid/out_ready for 10k cycles against a FIFO scoreboard -> no loss, duplication or reorder; count always equals outstanding entries.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// All outputs are registered; in_ready depends only on occupancy, never on out_ready.
module pipe_skid_stage #(
  parameter int unsigned        DATA_W   = 48,
  parameter int unsigned        CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] out_data_n;
  logic [CTRL_W-1:0] out_ctrl_n;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_n;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] skid_ctrl_n;
  logic [1:0]        count_n;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next contents of the main (output) and skid entries
  always_comb begin
    state_n     = state;
    out_data_n  = out_data;
    out_ctrl_n  = out_ctrl;
    skid_data_n = skid_data;
    skid_ctrl_n = skid_ctrl;

    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          out_data_n = in_data;
          out_ctrl_n = in_ctrl;
          state_n    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          out_data_n = in_data;
          out_ctrl_n = in_ctrl;
        end else if (in_fire) begin
          skid_data_n = in_data;
          skid_ctrl_n = in_ctrl;
          state_n     = ST_FULL;
        end else if (out_fire) begin
          out_ctrl_n = CTRL_RST;
          state_n    = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          out_data_n = skid_data;
          out_ctrl_n = skid_ctrl;
          state_n    = ST_ONE;
        end
      end
      default: begin
        out_ctrl_n = CTRL_RST;
        state_n    = ST_EMPTY;
      end
    endcase

    // Flush wins over any same-cycle transfer; out_data keeps its last value as a bubble.
    if (flush) begin
      state_n     = ST_EMPTY;
      out_data_n  = out_data;
      out_ctrl_n  = CTRL_RST;
      skid_data_n = skid_data;
      skid_ctrl_n = skid_ctrl;
    end
  end

  always_comb begin
    count_n = 2'd0;
    case (state_n)
      ST_ONE:  count_n = 2'd1;
      ST_FULL: count_n = 2'd2;
      default: count_n = 2'd0;
    endcase
  end

  // Registered outputs and skid storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= 2'd0;
      out_data  <= '0;
      out_ctrl  <= CTRL_RST;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      in_ready  <= (state_n != ST_FULL);
      out_valid <= (state_n != ST_EMPTY);
      count     <= count_n;
      out_data  <= out_data_n;
      out_ctrl  <= out_ctrl_n;
      skid_data <= skid_data_n;
      skid_ctrl <= skid_ctrl_n;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus random traffic
// compared against a queue-based FIFO model of the stage.
module tb_pipe_skid_stage;

  localparam int unsigned DATA_W = 48;
  localparam int unsigned CTRL_W = 8;
  localparam logic [CTRL_W-1:0] CRST = 8'hA5;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ent_t              q[$];
  logic [DATA_W-1:0] last_data;

  pipe_skid_stage #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CTRL_RST(CRST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with what the FIFO model says the stage holds.
  task automatic check_model(input string tag);
    chk({tag, ".count"},     64'(count),     64'(q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    chk({tag, ".out_data"},  64'(out_data),  64'(last_data));
    if (q.size() > 0) chk({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(q[0].c));
    else              chk({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(CRST));
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: decide transfers from the model, advance, then compare.
  task automatic cycle(input string tag);
    bit   acc;
    bit   pop;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    e.d = in_data;
    e.c = in_ctrl;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last_data = q[0].d;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    last_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;

    // Bubble control
    drive(1'b1, 48'h10, 8'h01, 1'b0, 1'b0);
    cycle("bubble_acc");
    chk("bubble_ctrl01", 64'(out_ctrl), 64'h01);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle("bubble_drain");
    chk("bubble_ctrlA5", 64'(out_ctrl), 64'hA5);

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1, 1'b0);
      cycle("stream");
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_count", 64'(count), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle("stream_drain");

    // Backpressure: A, B absorbed, C held upstream, then drained with no gap
    drive(1'b1, 48'hA, 8'h0A, 1'b0, 1'b0);
    cycle("bp_a");
    drive(1'b1, 48'hB, 8'h0B, 1'b0, 1'b0);
    cycle("bp_b");
    drive(1'b1, 48'hC, 8'h0C, 1'b0, 1'b0);
    cycle("bp_c_held");
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_full_data", 64'(out_data), 64'hA);
    drive(1'b1, 48'hC, 8'h0C, 1'b1, 1'b0);
    cycle("bp_out_b");
    chk("bp_b_out", 64'(out_data), 64'hB);
    cycle("bp_out_c");
    chk("bp_c_out", 64'(out_data), 64'hC);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle("bp_drain");

    // Flush while full with a simultaneous input
    drive(1'b1, 48'h1, 8'h11, 1'b0, 1'b0);
    cycle("fl_fill1");
    drive(1'b1, 48'h2, 8'h22, 1'b0, 1'b0);
    cycle("fl_fill2");
    drive(1'b1, 48'h55, 8'h55, 1'b0, 1'b1);
    cycle("flush");
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'(CRST));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle("post_flush");
    chk("flush_no55", 64'(out_data == 48'h55), 64'd0);

    // Asynchronous reset mid-cycle while holding two entries
    drive(1'b1, 48'h7, 8'h07, 1'b0, 1'b0);
    cycle("rst_fill1");
    drive(1'b1, 48'h8, 8'h08, 1'b0, 1'b0);
    cycle("rst_fill2");
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    last_data = '0;
    check_model("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model("rst_release");

    // Random traffic against the FIFO model
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 1)),
            {16'($urandom), 32'($urandom)},
            8'($urandom),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
